// File: rtl/game_pkg.sv
// Shared state encoding, widths and a saturating-increment helper for the Morse spy round controller.
package game_pkg;

  localparam int ROUND_W = 3;
  localparam int SCORE_W = 4;
  localparam int SEC_W   = 6;

  // SHOW and GAME_OVER share code 7; the game_over flag tells them apart.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_P1_ENTER = 3'd1,
    ST_P2_CLEAR = 3'd2,
    ST_P2_ENTER = 3'd3,
    ST_P2_CHECK = 3'd4,
    ST_WIN      = 3'd5,
    ST_LOSE     = 3'd6,
    ST_SHOW     = 3'd7
  } state_e;

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    logic [SCORE_W-1:0] r;
    if (v == {SCORE_W{1'b1}}) begin
      r = v;
    end else begin
      r = v + SCORE_W'(1);
    end
    return r;
  endfunction

endpackage

// File: rtl/round_controller_sec_timer.sv
// Per-attempt countdown: a prescaler dividing the clock into seconds and a
// seconds-remaining down-counter that stops at zero.
module sec_timer
  import game_pkg::*;
#(
  parameter int TICKS_PER_SEC = 50_000_000,
  parameter int GUESS_TIME    = 30
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clr,
  input  logic             load,
  input  logic             run,
  output logic [SEC_W-1:0] sec_left,
  output logic             expire
);

  localparam int PW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0]    PS_LAST = PW'(TICKS_PER_SEC - 1);
  localparam logic [PW-1:0]    PS_ONE  = PW'(1);
  localparam logic [SEC_W-1:0] SEC_ONE = SEC_W'(1);
  localparam logic [SEC_W-1:0] SEC_INI = SEC_W'(GUESS_TIME);

  logic [PW-1:0]    presc_q, presc_d;
  logic [SEC_W-1:0] sec_q, sec_d;
  logic             wrap_s;

  assign wrap_s   = run && (presc_q == PS_LAST);
  assign expire   = wrap_s && (sec_q == SEC_ONE);
  assign sec_left = sec_q;

  // Prescaler and seconds counter state
  always_ff @(posedge clock) begin
    if (reset) begin
      presc_q <= '0;
      sec_q   <= '0;
    end else begin
      presc_q <= presc_d;
      sec_q   <= sec_d;
    end
  end

  // Clear beats load beats run; the seconds count never goes below zero
  always_comb begin
    presc_d = presc_q;
    sec_d   = sec_q;
    if (clr) begin
      presc_d = '0;
      sec_d   = '0;
    end else if (load) begin
      presc_d = '0;
      sec_d   = SEC_INI;
    end else if (run) begin
      if (wrap_s) begin
        presc_d = '0;
        if (sec_q != '0) begin
          sec_d = sec_q - SEC_ONE;
        end else begin
          sec_d = sec_q;
        end
      end else begin
        presc_d = presc_q + PS_ONE;
      end
    end else begin
      presc_d = presc_q;
    end
  end

endmodule

// File: rtl/round_controller.sv
// Game sequencer for the Morse spy game: player-1 code entry, timed player-2
// guesses, scoring and round/game bookkeeping.
module round_controller
  import game_pkg::*;
#(
  parameter int TICKS_PER_SEC = 50_000_000,
  parameter int GUESS_TIME    = 30,
  parameter int MAX_ATTEMPTS  = 3,
  parameter int ROUNDS        = 5
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               p1_done,
  input  logic               p2_done,
  input  logic               p2_match,
  output logic               p1_en,
  output logic               p2_en,
  output logic               p2_clear,
  output logic [ROUND_W-1:0] round_idx,
  output logic [SCORE_W-1:0] p1_score,
  output logic [SCORE_W-1:0] p2_score,
  output logic [1:0]         attempts_left,
  output logic [SEC_W-1:0]   sec_left,
  output logic               timeout,
  output logic               round_won,
  output logic               game_over,
  output logic [2:0]         state
);

  localparam logic [1:0]         ATT_MAX    = 2'(MAX_ATTEMPTS);
  localparam logic [ROUND_W-1:0] ROUND_LAST = ROUND_W'(ROUNDS - 1);

  state_e             state_q, state_d;
  logic [ROUND_W-1:0] round_q, round_d;
  logic [SCORE_W-1:0] p1s_q, p1s_d, p2s_q, p2s_d;
  logic [1:0]         att_q, att_d;
  logic               timeout_q, timeout_d;
  logic               won_q, won_d;
  logic               go_q, go_d;
  logic               tmr_clr_s, tmr_load_s, tmr_run_s, expire_s;

  sec_timer #(
    .TICKS_PER_SEC(TICKS_PER_SEC),
    .GUESS_TIME   (GUESS_TIME)
  ) u_timer (
    .clock   (clock),
    .reset   (reset),
    .clr     (tmr_clr_s),
    .load    (tmr_load_s),
    .run     (tmr_run_s),
    .sec_left(sec_left),
    .expire  (expire_s)
  );

  assign p1_en         = (state_q == ST_P1_ENTER);
  assign p2_en         = (state_q == ST_P2_ENTER);
  assign p2_clear      = (state_q == ST_P2_CLEAR);
  assign round_idx     = round_q;
  assign p1_score      = p1s_q;
  assign p2_score      = p2s_q;
  assign attempts_left = att_q;
  assign timeout       = timeout_q;
  assign round_won     = won_q;
  assign game_over     = go_q;
  assign state         = state_q;

  // FSM and game counters
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      round_q   <= '0;
      p1s_q     <= '0;
      p2s_q     <= '0;
      att_q     <= '0;
      timeout_q <= 1'b0;
      won_q     <= 1'b0;
      go_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      round_q   <= round_d;
      p1s_q     <= p1s_d;
      p2s_q     <= p2s_d;
      att_q     <= att_d;
      timeout_q <= timeout_d;
      won_q     <= won_d;
      go_q      <= go_d;
    end
  end

  // Next-state and counter updates
  always_comb begin
    state_d    = state_q;
    round_d    = round_q;
    p1s_d      = p1s_q;
    p2s_d      = p2s_q;
    att_d      = att_q;
    timeout_d  = timeout_q;
    won_d      = won_q;
    go_d       = go_q;
    tmr_clr_s  = 1'b0;
    tmr_load_s = 1'b0;
    tmr_run_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          round_d = '0;
          p1s_d   = '0;
          p2s_d   = '0;
          state_d = ST_P1_ENTER;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_P1_ENTER: begin
        if (p1_done) begin
          att_d   = ATT_MAX;
          state_d = ST_P2_CLEAR;
        end else begin
          state_d = ST_P1_ENTER;
        end
      end
      ST_P2_CLEAR: begin
        tmr_load_s = 1'b1;
        state_d    = ST_P2_ENTER;
      end
      ST_P2_ENTER: begin
        tmr_run_s = 1'b1;
        // A submitted guess takes priority over a countdown expiring in the same cycle.
        if (p2_done) begin
          state_d = ST_P2_CHECK;
        end else if (expire_s) begin
          timeout_d = 1'b1;
          state_d   = ST_LOSE;
        end else begin
          state_d = ST_P2_ENTER;
        end
      end
      ST_P2_CHECK: begin
        if (p2_match) begin
          state_d = ST_WIN;
        end else if (att_q == 2'd1) begin
          state_d = ST_LOSE;
        end else begin
          att_d   = att_q - 2'd1;
          state_d = ST_P2_CLEAR;
        end
      end
      ST_WIN: begin
        p2s_d   = sat_inc(p2s_q);
        won_d   = 1'b1;
        state_d = ST_SHOW;
      end
      ST_LOSE: begin
        p1s_d   = sat_inc(p1s_q);
        won_d   = 1'b0;
        state_d = ST_SHOW;
      end
      ST_SHOW: begin
        if (!start) begin
          state_d = ST_SHOW;
        end else if (go_q) begin
          round_d   = '0;
          p1s_d     = '0;
          p2s_d     = '0;
          att_d     = '0;
          timeout_d = 1'b0;
          won_d     = 1'b0;
          go_d      = 1'b0;
          tmr_clr_s = 1'b1;
          state_d   = ST_IDLE;
        end else if (round_q == ROUND_LAST) begin
          go_d    = 1'b1;
          state_d = ST_SHOW;
        end else begin
          round_d   = round_q + ROUND_W'(1);
          timeout_d = 1'b0;
          won_d     = 1'b0;
          state_d   = ST_P1_ENTER;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_round_controller.sv
// Directed self-checking bench for round_controller with a short countdown
// (4 ticks/second, 3 seconds, 3 attempts, 2 rounds).
module tb_round_controller;

  logic       clock = 1'b0;
  logic       reset, start, p1_done, p2_done, p2_match;
  logic       p1_en, p2_en, p2_clear, timeout, round_won, game_over;
  logic [2:0] round_idx, state;
  logic [3:0] p1_score, p2_score;
  logic [1:0] attempts_left;
  logic [5:0] sec_left;

  int checks = 0;
  int errors = 0;
  int clr_pulses = 0;
  int clr_mark;

  round_controller #(
    .TICKS_PER_SEC(4),
    .GUESS_TIME   (3),
    .MAX_ATTEMPTS (3),
    .ROUNDS       (2)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .p1_done      (p1_done),
    .p2_done      (p2_done),
    .p2_match     (p2_match),
    .p1_en        (p1_en),
    .p2_en        (p2_en),
    .p2_clear     (p2_clear),
    .round_idx    (round_idx),
    .p1_score     (p1_score),
    .p2_score     (p2_score),
    .attempts_left(attempts_left),
    .sec_left     (sec_left),
    .timeout      (timeout),
    .round_won    (round_won),
    .game_over    (game_over),
    .state        (state)
  );

  always #5 clock = ~clock;

  // Count cycles with p2_clear high, sampled mid-cycle
  always @(negedge clock) begin
    if (p2_clear) clr_pulses++;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic pulse_p1();
    p1_done = 1'b1; step(); p1_done = 1'b0;
  endtask

  task automatic pulse_p2();
    p2_done = 1'b1; step(); p2_done = 1'b0;
  endtask

  function automatic logic [31:0] all_outs();
    return {4'd0, p1_en, p2_en, p2_clear, round_idx, p1_score, p2_score,
            attempts_left, sec_left, timeout, round_won, game_over, state};
  endfunction

  initial begin
    reset = 1'b1; start = 1'b0; p1_done = 1'b0; p2_done = 1'b0; p2_match = 1'b0;
    step(); step();
    reset = 1'b0;
    check_val("reset_outputs", all_outs(), 32'd0);

    // Round 0: immediate correct guess
    pulse_start();
    check_val("p1_enter_state", {29'd0, state}, 32'd1);
    check_val("p1_en", {31'd0, p1_en}, 32'd1);
    clr_mark = clr_pulses;
    pulse_p1();
    check_val("p2_clear_state", {29'd0, state}, 32'd2);
    check_val("attempts_init", {30'd0, attempts_left}, 32'd3);
    step();
    check_val("p2_enter_state", {29'd0, state}, 32'd3);
    check_val("sec_load", {26'd0, sec_left}, 32'd3);
    check_val("p2_en", {31'd0, p2_en}, 32'd1);
    p2_match = 1'b1;
    pulse_p2();
    check_val("check_state", {29'd0, state}, 32'd4);
    step();
    check_val("win_state", {29'd0, state}, 32'd5);
    step();
    check_val("show_state", {29'd0, state}, 32'd7);
    check_val("win_p2_score", {28'd0, p2_score}, 32'd1);
    check_val("win_round_won", {31'd0, round_won}, 32'd1);
    check_val("win_attempts", {30'd0, attempts_left}, 32'd3);
    check_val("win_clear_once", clr_pulses - clr_mark, 32'd1);

    // Round 1: three wrong guesses
    pulse_start();
    check_val("round1_idx", {29'd0, round_idx}, 32'd1);
    check_val("round1_won_clr", {31'd0, round_won}, 32'd0);
    clr_mark = clr_pulses;
    p2_match = 1'b0;
    pulse_p1();
    for (int i = 0; i < 3; i++) begin
      step();
      check_val("miss_attempts", {30'd0, attempts_left}, 32'(3 - i));
      pulse_p2();
      step();
    end
    check_val("miss_lose_state", {29'd0, state}, 32'd6);
    step();
    check_val("miss_p1_score", {28'd0, p1_score}, 32'd1);
    check_val("miss_timeout", {31'd0, timeout}, 32'd0);
    check_val("miss_clear_3x", clr_pulses - clr_mark, 32'd3);

    // Last round done: game over, then back to idle
    pulse_start();
    check_val("go_flag", {31'd0, game_over}, 32'd1);
    check_val("go_state", {29'd0, state}, 32'd7);
    check_val("go_scores", {24'd0, p1_score, p2_score}, 32'h11);
    pulse_start();
    check_val("idle_after_go", all_outs(), 32'd0);
    pulse_p1();
    pulse_p2();
    check_val("idle_stray", all_outs(), 32'd0);

    // New game round 0: countdown expiry
    pulse_start();
    pulse_p1();
    step();
    for (int k = 0; k < 12; k++) begin
      check_val("cd_state", {29'd0, state}, 32'd3);
      check_val("cd_sec", {26'd0, sec_left}, 32'(3 - k / 4));
      step();
    end
    check_val("to_lose_state", {29'd0, state}, 32'd6);
    check_val("to_sec_zero", {26'd0, sec_left}, 32'd0);
    step();
    check_val("to_timeout", {31'd0, timeout}, 32'd1);
    check_val("to_p1_score", {28'd0, p1_score}, 32'd1);
    check_val("to_round_won", {31'd0, round_won}, 32'd0);

    // Round 1: correct guess on the expiry cycle
    pulse_start();
    check_val("to_cleared", {31'd0, timeout}, 32'd0);
    pulse_p1();
    step();
    for (int k = 0; k < 11; k++) step();
    check_val("edge_sec", {26'd0, sec_left}, 32'd1);
    p2_match = 1'b1;
    pulse_p2();
    check_val("edge_check", {29'd0, state}, 32'd4);
    step();
    check_val("edge_win", {29'd0, state}, 32'd5);
    step();
    check_val("edge_won", {31'd0, round_won}, 32'd1);
    check_val("edge_timeout", {31'd0, timeout}, 32'd0);
    check_val("edge_scores", {24'd0, p1_score, p2_score}, 32'h11);

    // Reset in the middle of a countdown
    pulse_start();
    pulse_start();
    pulse_start();
    pulse_p1();
    step(); step(); step();
    check_val("pre_reset_state", {29'd0, state}, 32'd3);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_val("mid_reset", all_outs(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
